// File: rtl/alu_pkg.sv
// Shared width, opcode encoding and hold decode for the 4-bit accumulator ALU.
package alu_pkg;

   localparam int ALU_W = 4;

   typedef enum logic [3:0] {
      OP_PASSA = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_AND   = 4'd3,
      OP_OR    = 4'd4,
      OP_XOR   = 4'd5,
      OP_NOTA  = 4'd6,
      OP_SHL   = 4'd7,
      OP_SHR   = 4'd8,
      OP_INC   = 4'd9,
      OP_DEC   = 4'd10,
      OP_PASSB = 4'd11,
      OP_HOLD  = 4'd12
   } alu_op_e;

   // Codes 12..15 all freeze the result register.
   function automatic logic is_hold(input logic [3:0] sel);
      return sel >= OP_HOLD;
   endfunction

endpackage

// File: rtl/alu_datapath.sv
// Combinational function unit: selected result plus next carry/borrow.
module alu_datapath
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [3:0]       op,
   output logic [ALU_W-1:0] result,
   output logic             carry_next
);

   // One extra bit on each arithmetic path captures carry-out or borrow.
   logic [ALU_W:0] sum_wide;
   logic [ALU_W:0] diff_wide;
   logic [ALU_W:0] inc_wide;
   logic [ALU_W:0] dec_wide;

   assign sum_wide  = {1'b0, a} + {1'b0, b};
   assign diff_wide = {1'b0, a} - {1'b0, b};
   assign inc_wide  = {1'b0, a} + (ALU_W+1)'(1);
   assign dec_wide  = {1'b0, a} - (ALU_W+1)'(1);

   always_comb begin
      result     = '0;
      carry_next = 1'b0;
      case (alu_op_e'(op))
         OP_PASSA: result = a;
         OP_ADD: begin
            result     = sum_wide[ALU_W-1:0];
            carry_next = sum_wide[ALU_W];
         end
         OP_SUB: begin
            result     = diff_wide[ALU_W-1:0];
            carry_next = diff_wide[ALU_W];
         end
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_NOTA:  result = ~a;
         OP_SHL: begin
            result     = {a[ALU_W-2:0], 1'b0};
            carry_next = a[ALU_W-1];
         end
         OP_SHR: begin
            result     = {1'b0, a[ALU_W-1:1]};
            carry_next = a[0];
         end
         OP_INC: begin
            result     = inc_wide[ALU_W-1:0];
            carry_next = inc_wide[ALU_W];
         end
         OP_DEC: begin
            result     = dec_wide[ALU_W-1:0];
            carry_next = dec_wide[ALU_W];
         end
         OP_PASSB: result = b;
         default: begin
            result     = '0;
            carry_next = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_core.sv
// Registered 4-bit ALU, one-cycle latency. Define ALU_FLAGS_EN to add the
// registered carry and zero flags.
module alu_core
   import alu_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [3:0]       sel,
   output logic [ALU_W-1:0] out
`ifdef ALU_FLAGS_EN
   ,
   output logic             carry,
   output logic             zero
`endif
);

   logic [ALU_W-1:0] out_next;
   logic [ALU_W-1:0] out_reg;
   logic             hold;

   assign hold = is_hold(sel);

`ifdef ALU_FLAGS_EN
   logic carry_next;
   logic carry_reg;
   logic zero_reg;

   alu_datapath u_datapath (
      .a          (a),
      .b          (b),
      .op         (sel),
      .result     (out_next),
      .carry_next (carry_next)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_reg   <= '0;
         carry_reg <= 1'b0;
         zero_reg  <= 1'b1;
      end else if (!hold) begin
         out_reg   <= out_next;
         carry_reg <= carry_next;
         zero_reg  <= (out_next == '0);
      end
   end

   assign carry = carry_reg;
   assign zero  = zero_reg;
`else
   // Carry is still produced by the shared datapath but has no consumer here.
   logic unused_carry;

   alu_datapath u_datapath (
      .a          (a),
      .b          (b),
      .op         (sel),
      .result     (out_next),
      .carry_next (unused_carry)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_reg <= '0;
      end else if (!hold) begin
         out_reg <= out_next;
      end
   end
`endif

   assign out = out_reg;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core; flag checks are active when ALU_FLAGS_EN is defined.
module tb_alu_core;

   logic       clock;
   logic       reset_n;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] sel;
   logic [3:0] out_w;
`ifdef ALU_FLAGS_EN
   logic       carry_w;
   logic       zero_w;
`endif

   int check_count = 0;
   int fail_count  = 0;

   alu_core dut (
      .clock   (clock),
      .reset_n (reset_n),
      .a       (a),
      .b       (b),
      .sel     (sel),
      .out     (out_w)
`ifdef ALU_FLAGS_EN
      ,
      .carry   (carry_w),
      .zero    (zero_w)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      check_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one operation, clock it, then compare the registered outputs.
   task automatic apply(input string tag, input logic rn, input logic [3:0] ta,
                        input logic [3:0] tb, input logic [3:0] ts,
                        input logic [3:0] exp_out, input logic exp_c, input logic exp_z);
      @(negedge clock);
      reset_n = rn;
      a       = ta;
      b       = tb;
      sel     = ts;
      @(posedge clock);
      #1;
      $display("txn %-10s rst_n=%0b a=%h b=%h sel=%0d -> out=%h", tag, rn, ta, tb, ts, out_w);
      check({tag, ".out"}, out_w, exp_out);
`ifdef ALU_FLAGS_EN
      check({tag, ".carry"}, {3'b0, carry_w}, {3'b0, exp_c});
      check({tag, ".zero"}, {3'b0, zero_w}, {3'b0, exp_z});
`else
      if (exp_c === 1'bz || exp_z === 1'bz) $display("note: unexpected flag value");
`endif
   endtask

   initial begin
      logic [3:0] sweep_exp [1:8];
      logic       sweep_c   [1:8];
      sweep_exp = '{4'h5, 4'hF, 4'h2, 4'h3, 4'h1, 4'hD, 4'h4, 4'h1};
      sweep_c   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      reset_n = 1'b0;
      a       = 4'h5;
      b       = 4'h9;
      sel     = 4'd1;

      // Reset held for two edges with arbitrary operands
      apply("reset0", 1'b0, 4'h5, 4'h9, 4'd1, 4'h0, 1'b0, 1'b1);
      apply("reset1", 1'b0, 4'hA, 4'h7, 4'd7, 4'h0, 1'b0, 1'b1);

      // Sweep sel=1..8 with a=2, b=3
      for (int i = 1; i <= 8; i++) begin
         apply($sformatf("sweep%0d", i), 1'b1, 4'h2, 4'h3, 4'(i),
               sweep_exp[i], sweep_c[i], 1'b0);
      end

      // Wrap-around and shifts
      apply("add_wrap", 1'b1, 4'hF, 4'h1, 4'd1,  4'h0, 1'b1, 1'b1);
      apply("sub_wrap", 1'b1, 4'h0, 4'h1, 4'd2,  4'hF, 1'b1, 1'b0);
      apply("dec_wrap", 1'b1, 4'h0, 4'h3, 4'd10, 4'hF, 1'b1, 1'b0);
      apply("inc_wrap", 1'b1, 4'hF, 4'h0, 4'd9,  4'h0, 1'b1, 1'b1);
      apply("shl9",     1'b1, 4'h9, 4'h0, 4'd7,  4'h2, 1'b1, 1'b0);
      apply("shr9",     1'b1, 4'h9, 4'h0, 4'd8,  4'h4, 1'b1, 1'b0);
      apply("sub_eq",   1'b1, 4'h6, 4'h6, 4'd2,  4'h0, 1'b0, 1'b1);
      apply("passa0",   1'b1, 4'h0, 4'h5, 4'd0,  4'h0, 1'b0, 1'b1);

      // HOLD freezes out and flags while operands change
      apply("add7_1",   1'b1, 4'h7, 4'h1, 4'd1,  4'h8, 1'b0, 1'b0);
      apply("hold13",   1'b1, 4'h3, 4'h4, 4'd13, 4'h8, 1'b0, 1'b0);
      apply("hold12",   1'b1, 4'hF, 4'hF, 4'd12, 4'h8, 1'b0, 1'b0);
      apply("passb6",   1'b1, 4'h1, 4'h6, 4'd11, 4'h6, 1'b0, 1'b0);
      apply("add_c",    1'b1, 4'hF, 4'h1, 4'd1,  4'h0, 1'b1, 1'b1);
      apply("hold15",   1'b1, 4'h2, 4'h2, 4'd15, 4'h0, 1'b1, 1'b1);

      // Mid-stream reset pulse during an ADD sequence
      apply("mid_add0", 1'b1, 4'h1, 4'h1, 4'd1,  4'h2, 1'b0, 1'b0);
      apply("mid_rst",  1'b0, 4'h2, 4'h2, 4'd1,  4'h0, 1'b0, 1'b1);
      apply("mid_add1", 1'b1, 4'h3, 4'h3, 4'd1,  4'h6, 1'b0, 1'b0);
      apply("mid_add2", 1'b1, 4'h9, 4'h8, 4'd1,  4'h1, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
